// File: rtl/router_arb_pkg.sv
// Shared constants and index helpers for the router output-port arbiters.
package router_arb_pkg;

    localparam int MAX_INPUTS    = 16;
    localparam int MAX_IDX_WIDTH = $clog2(MAX_INPUTS);

    function automatic logic [MAX_IDX_WIDTH-1:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] onehot);
        logic [MAX_IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    // Increment modulo n, where n is the live port count (not a power of two in general).
    function automatic logic [MAX_IDX_WIDTH-1:0] wrap_inc(input logic [MAX_IDX_WIDTH-1:0] idx,
                                                          input logic [MAX_IDX_WIDTH:0] n);
        return ((MAX_IDX_WIDTH+1)'(idx) + (MAX_IDX_WIDTH+1)'(1) >= n) ? '0 : idx + MAX_IDX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/router_rr_select.sv
// Combinational circular priority search: first set req bit at or after ptr, wrapping to 0.
module router_rr_select
    import router_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 5,
    localparam int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_WIDTH-1:0]  ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [IDX_WIDTH-1:0]  idx
);

    logic [NUM_INPUTS-1:0] mask;
    logic [NUM_INPUTS-1:0] masked_req;
    logic [NUM_INPUTS-1:0] pick;

    // Thermometer mask keeps only bits at or above ptr; fall back to the full vector to wrap.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
            assign mask[gi] = (ptr <= IDX_WIDTH'(gi));
        end
    endgenerate

    assign masked_req = req & mask;
    assign pick       = (|masked_req) ? masked_req : req;
    assign grant      = pick & (~pick + NUM_INPUTS'(1));
    assign idx        = IDX_WIDTH'(onehot_to_idx(MAX_INPUTS'(grant)));

endmodule

// File: rtl/router_wrr_arbiter.sv
// N-input wormhole output arbiter with weighted round-robin priority and head-to-tail grant lock.
module router_wrr_arbiter
    import router_arb_pkg::*;
#(
    parameter  int NUM_INPUTS   = 5,
    parameter  int WEIGHT_WIDTH = 3,
    localparam int IDX_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_INPUTS-1:0]                    request,
    input  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0]  weight,
    input  logic                                     forwarding_head,
    input  logic                                     forwarding_tail,
    output logic [NUM_INPUTS-1:0]                    grant,
    output logic [IDX_WIDTH-1:0]                     grant_idx,
    output logic                                     grant_valid,
    output logic                                     locked
);

    localparam int CW = WEIGHT_WIDTH + 1;

    logic [IDX_WIDTH-1:0]    ptr_reg, ptr_next;
    logic [WEIGHT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                    lock_reg, lock_next;
    logic [IDX_WIDTH-1:0]    owner_reg, owner_next;

    logic [NUM_INPUTS-1:0]   sel_grant;
    logic [IDX_WIDTH-1:0]    sel_idx;
    logic [IDX_WIDTH-1:0]    sel_inc;
    logic [WEIGHT_WIDTH-1:0] w_sel;
    logic [WEIGHT_WIDTH-1:0] w_eff;
    logic [CW-1:0]           cnt_plus;
    logic                    head_event;
    logic                    tail_event;

    router_rr_select #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_select (
        .req   (request),
        .ptr   (ptr_reg),
        .grant (sel_grant),
        .idx   (sel_idx)
    );

    always_comb begin
        grant       = lock_reg ? (NUM_INPUTS'(1) << owner_reg) : sel_grant;
        grant_idx   = lock_reg ? owner_reg : sel_idx;
        grant_valid = (|request) & ~lock_reg;
        locked      = lock_reg;
    end

    assign head_event = forwarding_head & ~lock_reg & (|sel_grant);
    assign tail_event = forwarding_tail & lock_reg;
    assign w_sel      = weight[sel_idx];
    assign w_eff      = (w_sel == '0) ? WEIGHT_WIDTH'(1) : w_sel;
    assign cnt_plus   = CW'(cnt_reg) + CW'(1);
    assign sel_inc    = IDX_WIDTH'(wrap_inc(MAX_IDX_WIDTH'(sel_idx), (MAX_IDX_WIDTH+1)'(NUM_INPUTS)));

    always_comb begin
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        lock_next  = lock_reg;
        owner_next = owner_reg;
        if (head_event) begin
            owner_next = sel_idx;
            lock_next  = ~forwarding_tail;
            if (sel_idx == ptr_reg) begin
                if (cnt_plus < CW'(w_eff)) begin
                    cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + WEIGHT_WIDTH'(1);
                end else begin
                    ptr_next = sel_inc;
                    cnt_next = '0;
                end
            end else if (w_eff == WEIGHT_WIDTH'(1)) begin
                ptr_next = sel_inc;
                cnt_next = '0;
            end else begin
                // A non-pointer winner with weight > 1 takes over the turn and has used one slot.
                ptr_next = sel_idx;
                cnt_next = WEIGHT_WIDTH'(1);
            end
        end else if (tail_event) begin
            lock_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            lock_reg  <= 1'b0;
            owner_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            lock_reg  <= lock_next;
            owner_reg <= owner_next;
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_owner_held:    assert property (@(posedge clk) disable iff (rst) lock_reg |-> request[owner_reg]);
    a_no_head_lock:  assert property (@(posedge clk) disable iff (rst) !(forwarding_head && lock_reg));

endmodule

// File: tb/tb_router_wrr_arbiter.sv
// Directed and randomized checks of router_wrr_arbiter against a packet-level reference model.
module tb_router_wrr_arbiter;

    localparam int N = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    request = '0;
    logic [N-1:0][2:0] weight;
    logic            forwarding_head = 1'b0;
    logic            forwarding_tail = 1'b0;
    logic [N-1:0]    grant;
    logic [2:0]      grant_idx;
    logic            grant_valid;
    logic            locked;

    int total = 0;
    int bad   = 0;

    // Reference model state: priority pointer, packets used in this turn, lock and owner.
    int ptr_m = 0;
    int cnt_m = 0;
    int owner_m = 0;
    bit lock_m = 0;

    router_wrr_arbiter #(
        .NUM_INPUTS   (N),
        .WEIGHT_WIDTH (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .request         (request),
        .weight          (weight),
        .forwarding_head (forwarding_head),
        .forwarding_tail (forwarding_tail),
        .grant           (grant),
        .grant_idx       (grant_idx),
        .grant_valid     (grant_valid),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (lock_m) return owner_m;
        for (int k = 0; k < N; k++) begin
            if (request[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        int g;
        logic [N-1:0] eg;
        g  = model_winner();
        eg = (g < 0) ? '0 : N'(1 << g);
        check({tag, "_grant"}, 32'(grant), 32'(eg));
        check({tag, "_idx"}, 32'(grant_idx), (g < 0) ? 32'd0 : 32'(g));
        check({tag, "_valid"}, 32'(grant_valid), 32'((request != 0) && !lock_m));
        check({tag, "_locked"}, 32'(locked), 32'(lock_m));
    endtask

    task automatic model_edge(input bit h, input bit t);
        int g;
        int w;
        g = model_winner();
        if (h && !lock_m && g >= 0) begin
            w = (weight[g] == 0) ? 1 : int'(weight[g]);
            if (g == ptr_m) begin
                if (cnt_m + 1 < w) cnt_m = (cnt_m + 1 > 7) ? 7 : cnt_m + 1;
                else begin ptr_m = (g + 1) % N; cnt_m = 0; end
            end else if (w == 1) begin
                ptr_m = (g + 1) % N; cnt_m = 0;
            end else begin
                ptr_m = g; cnt_m = 1;
            end
            owner_m = g;
            lock_m  = !t;
        end else if (t && lock_m) begin
            lock_m = 0;
        end
    endtask

    task automatic model_reset();
        ptr_m = 0; cnt_m = 0; owner_m = 0; lock_m = 0;
    endtask

    // One cycle: drive the flit events, check combinational outputs, clock, advance the model.
    task automatic step(input bit h, input bit t, input string tag);
        forwarding_head = h;
        forwarding_tail = t;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge(h, t);
        #1;
        forwarding_head = 1'b0;
        forwarding_tail = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        request = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int fair_seq [6];
        int wt_seq [8];
        int sat_seq [9];
        int len;

        fair_seq = '{0, 1, 2, 3, 4, 0};
        wt_seq   = '{0, 2, 2, 2, 0, 2, 2, 2};
        sat_seq  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < N; i++) weight[i] = 3'd1;

        // Reset state
        #3;
        check_outputs("rst_idle");
        @(posedge clk);
        #1;
        rst = 1'b0;
        request = 5'b10110;
        #1;
        check("rst_rel_grant", 32'(grant), 32'h02);
        check("rst_rel_idx", 32'(grant_idx), 32'd1);
        check_outputs("rst_rel");

        // Fairness with single-flit packets
        do_reset();
        request = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("fair_seq", 32'(grant_idx), 32'(fair_seq[i]));
            step(1, 1, "fair");
        end

        // Weighted turn for input 2
        do_reset();
        weight[2] = 3'd3;
        request = 5'b00101;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("wt_seq", 32'(grant_idx), 32'(wt_seq[i]));
            step(1, 1, "wt");
        end
        weight[2] = 3'd1;

        // Wormhole lock: head from input 3, competing request arrives mid-packet
        do_reset();
        request = 5'b01000;
        step(1, 0, "worm_head");
        request = 5'b01010;
        step(0, 0, "worm_body");
        step(0, 0, "worm_body");
        #1;
        check("worm_tail_grant", 32'(grant), 32'h08);
        check("worm_tail_valid", 32'(grant_valid), 32'd0);
        step(0, 1, "worm_tail");
        request = 5'b00010;
        #1;
        check("worm_after_grant", 32'(grant), 32'h02);
        check_outputs("worm_after");

        // Pointer wrap from 4 to 0
        do_reset();
        request = 5'b01000;
        step(1, 1, "wrap_setup");
        request = 5'b00011;
        #1;
        check("wrap_idx", 32'(grant_idx), 32'd0);
        step(1, 1, "wrap");

        // Zero weights behave as one
        do_reset();
        for (int i = 0; i < N; i++) weight[i] = 3'd0;
        request = 5'b11111;
        for (int i = 0; i < 4; i++) step(1, 1, "w0");

        // Weight 7 gives seven back-to-back packets before moving on
        do_reset();
        for (int i = 0; i < N; i++) weight[i] = 3'd1;
        weight[1] = 3'd7;
        request = 5'b00011;
        for (int i = 0; i < 9; i++) begin
            #1;
            check("sat_seq", 32'(grant_idx), 32'(sat_seq[i]));
            step(1, 1, "sat");
        end
        weight[1] = 3'd1;

        // Ignored events: stray tail, head with nothing requested
        do_reset();
        request = 5'b11111;
        step(1, 1, "ign_setup");
        step(0, 1, "ign_tail");
        request = '0;
        step(1, 0, "ign_nohead");
        request = 5'b11111;
        step(0, 0, "ign_after");

        // Asynchronous reset mid-packet clears the lock without a clock edge
        do_reset();
        request = 5'b01000;
        step(1, 0, "arst_head");
        check("arst_locked_before", 32'(locked), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_locked_after", 32'(locked), 32'd0);
        check_outputs("arst");
        rst = 1'b0;

        // Randomized multi-flit traffic
        do_reset();
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < N; i++) weight[i] = 3'($urandom_range(0, 7));
            request = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) step(0, 1, "rnd_stray");
            len = $urandom_range(1, 3);
            step(1, len == 1, "rnd_head");
            for (int k = 2; k <= len; k++) step(0, k == len, "rnd_body");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_wrr_arbiter.md
# router_wrr_arbiter

Parametrised N-input to 1-output wormhole arbiter for the NoC router output ports, generalising the fixed 4- and 5-input arbiters to any port count. It adds per-input weighted round-robin: input i may win up to weight[i] consecutive packets before priority moves on. Grant is zero-cycle from request, locked from head flit to tail flit, and priority state changes only when a head flit is forwarded. One instance sits per output port, driven by the input-port routing logic.

## Interface
- NUM_INPUTS, default 5: number of requesting input ports; legal values are 2 to 16.
- WEIGHT_WIDTH, default 3: width of each per-input weight field.
- IDX_WIDTH, derived as $clog2(NUM_INPUTS): width of the grant index; not overridable.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- request  in  NUM_INPUTS  bit i is set when input i holds a valid flit routed to this output; it must stay stable for the whole packet.
- weight  in  NUM_INPUTS x WEIGHT_WIDTH  packets per turn for input i; a value of 0 is treated as 1; sampled only on a head event.
- forwarding_head  in  1  the head flit of the granted packet is forwarded this cycle.
- forwarding_tail  in  1  the tail flit of the current packet is forwarded this cycle.
- grant  out  NUM_INPUTS  one-hot or zero.
- grant_idx  out  IDX_WIDTH  binary index of grant; 0 when grant is zero.
- grant_valid  out  1  high when |request and not locked.
- locked  out  1  high while a packet is in flight, i.e. after its head and before its tail.

## Operation
- State registers:
  - ptr: highest-priority index.
  - cnt: packets already served to ptr in the current turn.
  - lock: wormhole lock flag.
  - owner: index of the locked input.
- Unlocked grant: the first set request bit found scanning circularly from ptr (ptr, ptr+1, …, wrapping to 0). Grant is zero when request is zero.
- Locked grant: grant = onehot(owner), independent of request; grant_valid = 0.
- A head event is forwarding_head with lock = 0 and grant nonzero. Let g be the granted index and w = max(weight[g], 1).
  - If g == ptr and cnt+1 < w: cnt <= cnt+1; ptr is unchanged.
  - If g == ptr and cnt+1 >= w: ptr <= g+1 mod N; cnt <= 0.
  - If g != ptr and w == 1: ptr <= g+1 mod N; cnt <= 0.
  - If g != ptr and w > 1: ptr <= g; cnt <= 1.
  - In all cases: owner <= g; lock <= 1, unless forwarding_tail is also high.
- Single-flit packet (head and tail in the same cycle): priority updates as above, and lock stays 0.
- A tail event (forwarding_tail with lock = 1) sets lock <= 0. ptr and cnt are unchanged.
- Events that are ignored and change no state:
  - forwarding_head while locked; a simulation assertion also fires.
  - forwarding_head with zero grant.
  - forwarding_tail while unlocked without a head.
- Wrap-around: ptr = N-1 advances to 0. cnt saturates at 2^WEIGHT_WIDTH - 1.
- Reset: ptr = 0, cnt = 0, lock = 0, owner = 0. All outputs are combinational.
  - With request = 0 after reset: grant = 0, grant_idx = 0, grant_valid = 0, locked = 0.
  - Reset asserted mid-packet clears the lock immediately (asynchronous).
- Assertions (non-synthesis):
  - grant is onehot0.
  - When locked, request[owner] stays high.
  - No head event occurs while locked.

## Timing
- Request to grant: 0 cycles (combinational).
- The head event is registered at the clock edge; new priority applies from the next cycle.
- Lock applies from the cycle after the head and is released in the cycle after the tail. The tail cycle itself still shows the locked grant.
- Back-to-back packets: a tail in cycle t allows a new head in cycle t+1. No bubble is required beyond this.
- Longest combinational path is the circular priority search: O(log N) depth with a doubled-vector or thermometer-mask implementation.

## Structure
- Package router_arb_pkg holds:
  - the maximum-input constant (16);
  - function onehot_to_idx;
  - function wrap_inc(idx, n).
- Sub-module router_rr_select: purely combinational circular priority search.
  - Inputs: req and ptr.
  - Outputs: onehot grant and index.
  - Parameterised by NUM_INPUTS; reusable by other router allocators.
- The top level holds ptr, cnt, lock and owner, the head/tail event decode, and the assertions. Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset release with NUM_INPUTS = 5, all weights 1, request = 5'b10110 → grant = 5'b00010, grant_idx = 1, grant_valid = 1, locked = 0.
- Fairness, all weights 1, request = all ones, single-flit packets (head+tail) every cycle → grant_idx sequence 0,1,2,3,4,0; locked never rises.
- Weighting: weight[2] = 3, others 1, request = 5'b00101, single-flit packets → grant_idx 0,2,2,2,0,2,2,2.
- Wormhole lock: head from input 3 at cycle 1, request[1] raised at cycle 2, tail at cycle 5:
  - cycles 2–5: grant = 5'b01000, grant_valid = 0;
  - cycle 6: grant = 5'b00010.
- Boundaries:
  - ptr = 4 with request = 5'b00011 → grant_idx 0 (wrap).
  - weight = 0 → behaves as 1.
  - cnt saturates at 7.
  - Asynchronous rst mid-packet → locked = 0 with no clock edge.
- Illegal events: a second head while locked, and a tail while unlocked → state unchanged; the assertion fires only for the head case.
